// File: rtl/instruction_fetch.sv
// Instruction fetch stage: captures a PC, bursts WORDS bytes from the memory
// controller, and queues {PC, instruction} pairs for the pipeline.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 2,
    parameter int DEPTH      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_DIR,
    input  logic [ADDR_WIDTH-1:0]         addr_in,
    output logic                          in_ack,
    output logic                          mem_en,
    output logic                          mem_burst_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_di,
    input  logic                          mem_do_ack,
    input  logic [DATA_WIDTH-1:0]         mem_do,
    output logic                          out_DOR,
    input  logic                          out_ack,
    output logic [WORDS*DATA_WIDTH-1:0]   insn_out,
    output logic [ADDR_WIDTH-1:0]         pc_out
);
    localparam int INSN_W = WORDS * DATA_WIDTH;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] base;
    logic [IDX_W-1:0]      idx;
    logic                  in_ack_q;
    logic [INSN_W-1:0]     lanes;
    logic [INSN_W-1:0]     assembled;
    logic [INSN_W-1:0]     insn_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  capture, beat, last_beat, push, pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        capture      = 1'b0;
        beat         = 1'b0;
        last_beat    = 1'b0;
        mem_en       = 1'b0;
        mem_burst_en = 1'b0;
        mem_addr     = '0;
        case (state)
            IDLE: begin
                // Only accept while a FIFO slot is guaranteed for the result.
                if (in_DIR && !in_ack_q && (count < FULL_CNT)) begin
                    capture    = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                mem_en       = 1'b1;
                mem_burst_en = (WORDS > 1);
                mem_addr     = base + ADDR_WIDTH'(idx);
                beat         = mem_do_ack;
                last_beat    = mem_do_ack && (idx == LAST_IDX);
                if (last_beat) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ack_q <= 1'b0;
            base     <= '0;
            idx      <= '0;
        end else begin
            in_ack_q <= capture;
            if (capture) begin
                base <= addr_in;
                idx  <= '0;
            end else if (beat) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Merge the arriving byte into its lane so the last beat can push directly.
    always_comb begin
        assembled = lanes;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) assembled[i*DATA_WIDTH +: DATA_WIDTH] = mem_do;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) lanes <= assembled;
    end

    assign push = last_beat;
    assign pop  = out_ack && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            insn_mem[wr_ptr] <= assembled;
            pc_mem[wr_ptr]   <= base;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign in_ack   = in_ack_q;
    assign mem_di   = '0;
    assign out_DOR  = (count != '0);
    // Head is masked while empty so reset shows zeros without clearing storage.
    assign insn_out = out_DOR ? insn_mem[rd_ptr] : '0;
    assign pc_out   = out_DOR ? pc_mem[rd_ptr]   : '0;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vectors and corner sequences plus a
// randomized run, all checked against a transaction-level reference model.
module tb_instruction_fetch;
    localparam int A = 8;
    localparam int DW = 8;
    localparam int W = 2;
    localparam int D = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_DIR;
    logic [A-1:0]    addr_in;
    logic            in_ack;
    logic            mem_en;
    logic            mem_burst_en;
    logic [A-1:0]    mem_addr;
    logic [DW-1:0]   mem_di;
    logic            mem_do_ack;
    logic [DW-1:0]   mem_do;
    logic            out_DOR;
    logic            out_ack;
    logic [W*DW-1:0] insn_out;
    logic [A-1:0]    pc_out;

    instruction_fetch #(.ADDR_WIDTH(A), .DATA_WIDTH(DW), .WORDS(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_DIR(in_DIR), .addr_in(addr_in), .in_ack(in_ack),
        .mem_en(mem_en), .mem_burst_en(mem_burst_en), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_do_ack(mem_do_ack), .mem_do(mem_do), .out_DOR(out_DOR), .out_ack(out_ack),
        .insn_out(insn_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [A-1:0]    pc;
        logic [W*DW-1:0] insn;
    } entry_t;

    typedef struct {
        logic [A-1:0]    addr;
        logic [W*DW-1:0] insn;
    } vec_t;

    int passed = 0;
    int total  = 0;

    // Stimulus intent for the next cycle
    logic         d_dir, d_oack, d_mack;
    logic [A-1:0] d_addr;

    // Reference model: one in-flight fetch plus a queue of finished entries
    bit            m_busy, m_in_ack;
    logic [A-1:0]  m_pc;
    int            m_idx;
    logic [W*DW-1:0] m_insn;
    entry_t        q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_to(input string name);
        total++;
        $display("FAIL %s: got no event within bound, expected one", name);
    endtask

    // memory[a] = a + 0x10; byte k of an instruction comes from pc + k
    function automatic logic [W*DW-1:0] ref_insn(input logic [A-1:0] pc);
        logic [W*DW-1:0] r;
        logic [A-1:0]    a;
        r = '0;
        for (int k = 0; k < W; k++) begin
            a = pc + A'(k);
            r[k*DW +: DW] = a + 8'h10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_in_ack = 0; m_idx = 0; m_pc = '0; m_insn = '0;
        q.delete();
    endtask

    task automatic tick();
        bit cap, pop_e, beat;
        logic [A-1:0] a;
        entry_t e;
        in_DIR  = d_dir;
        addr_in = d_addr;
        out_ack = d_oack;
        beat = d_mack && m_busy;
        mem_do_ack = beat;
        a = m_pc + A'(m_idx);
        mem_do = a + 8'h10;
        cap   = !m_busy && d_dir && !m_in_ack && (q.size() < D);
        pop_e = d_oack && (q.size() != 0);
        @(posedge clk); #1;
        if (pop_e) q.delete(0);
        if (beat) begin
            if (m_idx == W - 1) begin
                e.pc = m_pc; e.insn = m_insn;
                q.push_back(e);
                m_busy = 0;
            end else begin
                m_idx++;
            end
        end
        if (cap) begin
            m_busy = 1; m_pc = d_addr; m_idx = 0; m_insn = ref_insn(d_addr);
        end
        m_in_ack = cap;
        check("in_ack", in_ack, m_in_ack);
        check("mem_en", mem_en, m_busy);
        check("mem_burst_en", mem_burst_en, m_busy);
        check("mem_di", mem_di, 0);
        if (m_busy) begin
            a = m_pc + A'(m_idx);
            check("mem_addr", mem_addr, a);
        end
        check("out_DOR", out_DOR, q.size() != 0);
        if (q.size() != 0) begin
            check("pc_out", pc_out, q[0].pc);
            check("insn_out", insn_out, q[0].insn);
        end
    endtask

    task automatic fetch(input logic [A-1:0] a);
        bit got;
        got = 0;
        d_dir = 1; d_addr = a; d_mack = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (m_in_ack) got = 1;
        end
        d_dir = 0;
        if (!got) fail_to("fetch_accept");
    endtask

    task automatic wait_dor();
        for (int i = 0; i < 20 && !out_DOR; i++) tick();
        if (!out_DOR) fail_to("wait_dor");
    endtask

    task automatic pop_one();
        d_oack = 1; tick(); d_oack = 0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{addr: 8'h01, insn: 16'h1211};
        vecs[1] = '{addr: 8'hFF, insn: 16'h100F};
        vecs[2] = '{addr: 8'h05, insn: 16'h1615};
        vecs[3] = '{addr: 8'h7F, insn: 16'h908F};
        vecs[4] = '{addr: 8'hEF, insn: 16'h00FF};
        vecs[5] = '{addr: 8'h00, insn: 16'h1110};

        reset = 0; in_DIR = 0; addr_in = '0; out_ack = 0; mem_do_ack = 0; mem_do = '0;
        d_dir = 0; d_oack = 0; d_mack = 1; d_addr = '0;
        model_reset();
        #12;
        check("rst_in_ack", in_ack, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_burst_en", mem_burst_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_di", mem_di, 0);
        check("rst_out_DOR", out_DOR, 0);
        check("rst_insn_out", insn_out, 0);
        check("rst_pc_out", pc_out, 0);
        @(posedge clk); #1;
        reset = 1;

        // Basic fetch with exact latency
        fetch(8'h01);
        check("basic_in_ack", in_ack, 1);
        check("basic_addr0", mem_addr, 8'h01);
        check("basic_dor_early", out_DOR, 0);
        tick();
        check("basic_addr1", mem_addr, 8'h02);
        check("basic_ack_pulse", in_ack, 0);
        check("basic_dor_mid", out_DOR, 0);
        tick();
        check("basic_dor", out_DOR, 1);
        check("basic_insn", insn_out, 16'h1211);
        check("basic_pc", pc_out, 8'h01);
        check("basic_mem_off", mem_en, 0);
        tick(); tick();
        check("basic_dor_held", out_DOR, 1);
        pop_one();
        check("basic_popped", out_DOR, 0);

        // Stall mid-burst
        fetch(8'h01);
        tick();
        d_mack = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_addr", mem_addr, 8'h02);
            check("stall_en", mem_en, 1);
        end
        d_mack = 1;
        tick();
        check("stall_insn", insn_out, 16'h1211);
        pop_one();

        // Address wrap
        fetch(8'hFF);
        check("wrap_addr0", mem_addr, 8'hFF);
        tick();
        check("wrap_addr1", mem_addr, 8'h00);
        tick();
        check("wrap_insn", insn_out, 16'h100F);
        check("wrap_pc", pc_out, 8'hFF);
        pop_one();

        // Table-driven fetches
        for (int v = 0; v < 6; v++) begin
            fetch(vecs[v].addr);
            wait_dor();
            check("vec_insn", insn_out, vecs[v].insn);
            check("vec_pc", pc_out, vecs[v].addr);
            pop_one();
        end

        // FIFO full blocks acceptance
        fetch(8'h01);
        fetch(8'h02);
        repeat (3) tick();
        check("full_head", pc_out, 8'h01);
        d_dir = 1; d_addr = 8'h03;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_no_ack", in_ack, 0);
            check("full_no_mem", mem_en, 0);
        end
        pop_one();
        check("full_head2", pc_out, 8'h02);
        tick();
        check("full_accept", in_ack, 1);
        d_dir = 0;
        tick(); tick();
        check("full_order2", pc_out, 8'h02);
        pop_one();
        check("full_order3", pc_out, 8'h03);
        check("full_dor3", out_DOR, 1);
        pop_one();
        check("full_empty", out_DOR, 0);

        // Simultaneous push and pop with one entry held
        fetch(8'h20);
        tick(); tick();
        check("sim_head", pc_out, 8'h20);
        fetch(8'h30);
        tick();
        d_oack = 1; tick(); d_oack = 0;
        check("sim_dor", out_DOR, 1);
        check("sim_pc", pc_out, 8'h30);
        check("sim_insn", insn_out, 16'h4140);
        tick();
        check("sim_count1", out_DOR, 1);
        pop_one();
        check("sim_empty", out_DOR, 0);

        // Reset in the middle of a burst
        fetch(8'h40);
        tick(); tick();
        fetch(8'h05);
        tick();
        #2;
        reset = 0;
        #1;
        check("arst_mem_en", mem_en, 0);
        check("arst_in_ack", in_ack, 0);
        check("arst_out_DOR", out_DOR, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_insn", insn_out, 0);
        check("arst_pc", pc_out, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1;
        fetch(8'h05);
        wait_dor();
        check("arst_new_insn", insn_out, 16'h1615);
        check("arst_new_pc", pc_out, 8'h05);
        pop_one();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            d_dir  = 1'($urandom_range(0, 1));
            d_addr = 8'($urandom);
            d_mack = ($urandom_range(0, 3) != 0);
            d_oack = (i < 200) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            tick();
        end
        d_dir = 0; d_mack = 1; d_oack = 1;
        repeat (10) tick();
        d_oack = 0;
        check("drain_empty", out_DOR, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
